// File: rtl/thor2025_reg_release_pkg.sv
// Thor2025 shared definitions for the physical-register release block:
// sizes, the tag type and the release FSM states.
package thor2025_reg_release_pkg;

   localparam int THOR_PREG   = 96;
   localparam int THOR_NFTAGS = 19;
   localparam int THOR_NCMT   = 3;
   localparam int THOR_NFLUSH = THOR_NFTAGS - THOR_NCMT;
   localparam int TAG_W       = 7;

   typedef logic [TAG_W-1:0] tag_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } rel_state_t;

endpackage

// File: rtl/thor2025_reg_release_if.sv
// Bus between the renamer/commit/flush logic and the register release block;
// the master side drives snoops and releases, the slave side returns free tags.
interface thor2025_reg_release_if
   import thor2025_reg_release_pkg::*;
#(
   parameter int PREG   = THOR_PREG,
   parameter int NFTAGS = THOR_NFTAGS,
   parameter int NCMT   = THOR_NCMT
);

   logic [2:0]             alloc_v;
   tag_t [2:0]             alloc_tag;
   logic [NCMT-1:0]        cmt_v;
   tag_t [NCMT-1:0]        cmt_tag;
   logic                   flush;
   logic [PREG-1:0]        flush_mask;
   tag_t [NFTAGS-1:0]      tags2free;
   logic [NFTAGS-1:0]      freevals;
   logic                   busy;
   logic                   dbl_free;

   modport master (
      output alloc_v, alloc_tag, cmt_v, cmt_tag, flush, flush_mask,
      input  tags2free, freevals, busy, dbl_free
   );

   modport slave (
      input  alloc_v, alloc_tag, cmt_v, cmt_tag, flush, flush_mask,
      output tags2free, freevals, busy, dbl_free
   );

endinterface

// File: rtl/thor2025_reg_release_pick16.sv
// Thor2025 pick16: combinational extractor of the lowest NPICK set bits of a
// bitmap, returned as ascending tags with a valid mask and the picked bitmap.
module thor2025_reg_release_pick16
   import thor2025_reg_release_pkg::*;
#(
   parameter int NBITS = THOR_PREG,
   parameter int NPICK = THOR_NFLUSH
) (
   input  logic [NBITS-1:0] bits,
   output tag_t [NPICK-1:0] tags,
   output logic [NPICK-1:0] vals,
   output logic [NBITS-1:0] taken
);

   localparam int CW = $clog2(NPICK);
   localparam logic [CW:0] PICK_MAX = (CW+1)'(NPICK);

   logic [CW:0] cnt_s;

   // Scan upward, filling output slots in order until NPICK bits are taken.
   always_comb begin
      tags  = '0;
      vals  = '0;
      taken = '0;
      cnt_s = '0;
      for (int i = 0; i < NBITS; i++) begin
         if (bits[i] && (cnt_s < PICK_MAX)) begin
            tags[cnt_s[CW-1:0]] = i[TAG_W-1:0];
            vals[cnt_s[CW-1:0]] = 1'b1;
            taken[i]            = 1'b1;
            cnt_s               = cnt_s + (CW+1)'(1);
         end else begin
            cnt_s = cnt_s;
         end
      end
   end

endmodule

// File: rtl/thor2025_reg_release.sv
// Thor2025 register release: forwards legal commit releases and drains flushed
// speculative tags back to the renamer free list, tracking tags in use.
module thor2025_reg_release
   import thor2025_reg_release_pkg::*;
#(
   parameter int PREG   = THOR_PREG,
   parameter int NFTAGS = THOR_NFTAGS,
   parameter int NCMT   = THOR_NCMT
) (
   input logic                  clk,
   input logic                  rst,
   thor2025_reg_release_if.slave bus
);

   localparam int NFL = NFTAGS - NCMT;

   rel_state_t          state_r, state_n;
   logic [PREG-1:0]     inuse_r, inuse_n;
   logic [PREG-1:0]     pending_r, pending_n;
   logic [NFTAGS-1:0]   freevals_r;
   tag_t [NFTAGS-1:0]   tags2free_r;
   logic                busy_r;
   logic                dbl_free_r;

   logic [NCMT-1:0]     cmt_hit_s, cmt_dup_s, cmt_ok_s;
   logic                cmt_bad_s;
   logic [PREG-1:0]     cmt_clr_s;
   logic [PREG-1:0]     alloc_s;
   logic [PREG-1:0]     flush_new_s;
   logic [PREG-1:0]     drain_src_s;
   tag_t [NFL-1:0]      pick_tags_s;
   logic [NFL-1:0]      pick_vals_s;
   logic [PREG-1:0]     pick_taken_s;

   // Commit legality: tag in range and in use, and not repeated by a lower slot.
   always_comb begin
      cmt_hit_s = '0;
      cmt_dup_s = '0;
      cmt_ok_s  = '0;
      cmt_clr_s = '0;
      for (int i = 0; i < NCMT; i++) begin
         for (int p = 0; p < PREG; p++) begin
            cmt_hit_s[i] = cmt_hit_s[i] | (inuse_r[p] & (bus.cmt_tag[i] == p[TAG_W-1:0]));
         end
         for (int j = 0; j < i; j++) begin
            cmt_dup_s[i] = cmt_dup_s[i] | (bus.cmt_v[j] & (bus.cmt_tag[j] == bus.cmt_tag[i]));
         end
         cmt_ok_s[i] = bus.cmt_v[i] & cmt_hit_s[i] & ~cmt_dup_s[i];
      end
      for (int p = 0; p < PREG; p++) begin
         for (int i = 0; i < NCMT; i++) begin
            cmt_clr_s[p] = cmt_clr_s[p] | (cmt_ok_s[i] & (bus.cmt_tag[i] == p[TAG_W-1:0]));
         end
      end
      cmt_bad_s = |(bus.cmt_v & ~cmt_ok_s);
   end

   // Decode the renamer grant snoop into a bitmap; out-of-range tags are ignored.
   always_comb begin
      alloc_s = '0;
      for (int p = 0; p < PREG; p++) begin
         for (int k = 0; k < 3; k++) begin
            alloc_s[p] = alloc_s[p] | (bus.alloc_v[k] & (bus.alloc_tag[k] == p[TAG_W-1:0]));
         end
      end
   end

   // Commit wins: a tag released by commit this cycle never leaves via a flush slot.
   assign drain_src_s = (state_r == ST_DRAIN) ? (pending_r & ~cmt_clr_s) : '0;

   thor2025_reg_release_pick16 #(
      .NBITS (PREG),
      .NPICK (NFL)
   ) u_pick (
      .bits  (drain_src_s),
      .tags  (pick_tags_s),
      .vals  (pick_vals_s),
      .taken (pick_taken_s)
   );

   // Next-state and pending-set update for the flush reclaim FSM.
   always_comb begin
      state_n     = state_r;
      pending_n   = pending_r;
      flush_new_s = bus.flush ? (bus.flush_mask & inuse_r & ~cmt_clr_s) : '0;
      case (state_r)
         ST_IDLE: begin
            if (|flush_new_s) begin
               state_n   = ST_DRAIN;
               pending_n = flush_new_s;
            end else begin
               state_n   = ST_IDLE;
               pending_n = '0;
            end
         end
         ST_DRAIN: begin
            pending_n = (drain_src_s | flush_new_s) & ~pick_taken_s;
            if (|pending_n) begin
               state_n = ST_DRAIN;
            end else begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n   = ST_IDLE;
            pending_n = '0;
         end
      endcase
      inuse_n = (inuse_r & ~cmt_clr_s & ~pick_taken_s) | alloc_s;
   end

   // State, bitmaps and registered free-list outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         inuse_r     <= '0;
         pending_r   <= '0;
         freevals_r  <= '0;
         tags2free_r <= '0;
         busy_r      <= 1'b0;
         dbl_free_r  <= 1'b0;
      end else begin
         state_r     <= state_n;
         inuse_r     <= inuse_n;
         pending_r   <= pending_n;
         freevals_r  <= {pick_vals_s, cmt_ok_s};
         tags2free_r <= {pick_tags_s, bus.cmt_tag};
         busy_r      <= (state_n == ST_DRAIN);
         dbl_free_r  <= dbl_free_r | cmt_bad_s;
      end
   end

   assign bus.freevals  = freevals_r;
   assign bus.tags2free = tags2free_r;
   assign bus.busy      = busy_r;
   assign bus.dbl_free  = dbl_free_r;

endmodule

// File: tb/tb_thor2025_reg_release.sv
// Self-checking bench for thor2025_reg_release: directed scenarios push the
// expected registered outputs into a scoreboard that is compared after each edge.
module tb_thor2025_reg_release;
   import thor2025_reg_release_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   thor2025_reg_release_if bus ();

   thor2025_reg_release dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [THOR_NFTAGS-1:0] fv;
      tag_t [THOR_NFTAGS-1:0] tg;
      logic                   busy;
      logic                   dbl;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   logic exp_dbl;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic idle_inputs();
      bus.alloc_v    = '0;
      bus.alloc_tag  = '0;
      bus.cmt_v      = '0;
      bus.cmt_tag    = '0;
      bus.flush      = 1'b0;
      bus.flush_mask = '0;
   endtask

   task automatic exp_clear(input logic busy_v);
      e.fv   = '0;
      e.tg   = '0;
      e.busy = busy_v;
      e.dbl  = exp_dbl;
   endtask

   task automatic exp_slot(input int s, input int t);
      e.fv[s] = 1'b1;
      e.tg[s] = 7'(t);
   endtask

   // One clock: push the expectation, let the edge happen, then pop and compare.
   task automatic step();
      exp_t want;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      want = sb_q.pop_front();
      check_val("freevals", 32'(bus.freevals), 32'(want.fv));
      check_val("busy", 32'(bus.busy), 32'(want.busy));
      check_val("dbl_free", 32'(bus.dbl_free), 32'(want.dbl));
      for (int i = 0; i < THOR_NFTAGS; i++) begin
         if (want.fv[i]) check_val($sformatf("tags2free[%0d]", i), 32'(bus.tags2free[i]), 32'(want.tg[i]));
      end
      idle_inputs();
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      exp_dbl = 1'b0;
      exp_clear(1'b0);
      step();
      rst = 1'b0;
   endtask

   task automatic alloc_range(input int lo, input int hi);
      for (int t = lo; t <= hi; t += 3) begin
         for (int k = 0; k < 3; k++) begin
            if (t + k <= hi) begin
               bus.alloc_v[k]   = 1'b1;
               bus.alloc_tag[k] = 7'(t + k);
            end
         end
         exp_clear(1'b0);
         step();
      end
   endtask

   task automatic commit(input int s, input int t);
      bus.cmt_v[s]   = 1'b1;
      bus.cmt_tag[s] = 7'(t);
   endtask

   initial begin
      rst = 1'b1;
      exp_dbl = 1'b0;
      idle_inputs();
      exp_clear(1'b0);

      // Reset state
      do_reset();

      // Basic commit release of 5,6 after allocating 5,6,7
      alloc_range(5, 7);
      commit(0, 5); commit(1, 6);
      exp_clear(1'b0); exp_slot(0, 5); exp_slot(1, 6);
      step();
      commit(0, 5);
      exp_dbl = 1'b1; exp_clear(1'b0);
      step();
      commit(0, 7);
      exp_clear(1'b0); exp_slot(0, 7);
      step();

      // Release of a never-allocated tag is dropped and sticks dbl_free
      do_reset();
      commit(0, 9);
      exp_dbl = 1'b1; exp_clear(1'b0);
      step();
      for (int k = 0; k < 3; k++) begin
         exp_clear(1'b0);
         step();
      end
      alloc_range(9, 9);
      commit(0, 9); commit(1, 9);
      exp_clear(1'b0); exp_slot(0, 9);
      step();

      // Full flush of all 96 tags: six drain cycles, ascending
      do_reset();
      alloc_range(0, 95);
      bus.flush = 1'b1; bus.flush_mask = '1;
      exp_clear(1'b1);
      step();
      for (int k = 0; k < 6; k++) begin
         exp_clear(k < 5);
         for (int j = 0; j < 16; j++) exp_slot(3 + j, 16 * k + j);
         step();
      end
      commit(0, 0); commit(1, 95);
      exp_dbl = 1'b1; exp_clear(1'b0);
      step();

      // Commit of 45 during a drain of 40..60 takes priority over the flush slots
      do_reset();
      alloc_range(40, 60);
      bus.flush = 1'b1; bus.flush_mask = '1;
      exp_clear(1'b1);
      step();
      commit(0, 45);
      exp_clear(1'b1); exp_slot(0, 45);
      begin
         int s;
         s = 3;
         for (int t = 40; t <= 56; t++) begin
            if (t != 45) begin
               exp_slot(s, t);
               s++;
            end
         end
      end
      step();
      exp_clear(1'b0);
      for (int j = 0; j < 4; j++) exp_slot(3 + j, 57 + j);
      step();
      exp_clear(1'b0);
      step();

      // Second flush mid-drain adds 80,81; 5 and 20 must not be repeated
      do_reset();
      alloc_range(0, 95);
      bus.flush = 1'b1;
      for (int t = 0; t < 32; t++) bus.flush_mask[t] = 1'b1;
      exp_clear(1'b1);
      step();
      bus.flush = 1'b1;
      bus.flush_mask[5] = 1'b1; bus.flush_mask[20] = 1'b1;
      bus.flush_mask[80] = 1'b1; bus.flush_mask[81] = 1'b1;
      exp_clear(1'b1);
      for (int j = 0; j < 16; j++) exp_slot(3 + j, j);
      step();
      exp_clear(1'b1);
      for (int j = 0; j < 16; j++) exp_slot(3 + j, 16 + j);
      step();
      exp_clear(1'b0); exp_slot(3, 80); exp_slot(4, 81);
      step();
      exp_clear(1'b0);
      step();

      // Reset in the second drain cycle abandons pending frees and clears dbl_free
      do_reset();
      alloc_range(0, 95);
      commit(0, 100);
      exp_dbl = 1'b1; exp_clear(1'b0);
      step();
      bus.flush = 1'b1; bus.flush_mask = '1;
      exp_clear(1'b1);
      step();
      exp_clear(1'b1);
      for (int j = 0; j < 16; j++) exp_slot(3 + j, j);
      step();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         exp_clear(1'b0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
